// File: rtl/ebox_pkg.sv
// ebox_pkg: shared EBOX types for the EDP diagnostic path.
// Diag sub-selects, snapshot states and the DIAG function code.
package ebox_pkg;

  typedef enum logic [2:0] {
    dsAR  = 3'd0,
    dsBR  = 3'd1,
    dsMQ  = 3'd2,
    dsFM  = 3'd3,
    dsBRX = 3'd4,
    dsARX = 3'd5,
    dsADX = 3'd6,
    dsAD  = 3'd7
  } tDiagSel;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ISSUE = 3'd2,
    CAPT  = 3'd3,
    DRAIN = 3'd4
  } tSnapState;

  // DIAG function 12x; the low octal digit is the sub-select.
  localparam logic [6:0] DIAG_FUNC_12X = 7'o120;

endpackage

// File: rtl/edp_diag_snap_if.sv
// edp_diag_snap_if: EBUS side and stream side of the snapshot unit.
// master = sequencer, slave = EBUS/EDP/front-end environment.
interface edp_diag_snap_if;
  logic        ebus_req;
  logic        ebus_grant;
  logic        ad_to_ebus;
  logic        diag_read;
  logic [2:0]  diag_sel;
  logic [35:0] ebus_data;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_data;
  logic [2:0]  out_sel;
  logic        out_par;
  logic        out_last;

  modport master (
    output ebus_req, diag_read, diag_sel,
    output out_valid, out_data, out_sel,
    output out_par, out_last,
    input  ebus_grant, ad_to_ebus, ebus_data,
    input  out_ready
  );

  modport slave (
    input  ebus_req, diag_read, diag_sel,
    input  out_valid, out_data, out_sel,
    input  out_par, out_last,
    output ebus_grant, ad_to_ebus, ebus_data,
    output out_ready
  );
endinterface

// File: rtl/prio_enc8.sv
// prio_enc8: index of the lowest set bit of an 8-bit vector.
// none=1 when no bit is set (idx is then 0).
module prio_enc8 (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       none
);

  // scan high to low so the lowest set bit wins
  always_comb begin
    idx  = 3'd0;
    none = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        idx  = 3'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/edp_diag_snap.sv
// edp_diag_snap: steps the EDP diag read mux, captures EBUS words,
// then streams the captured words to the front-end.
module edp_diag_snap
  import ebox_pkg::*;
#(
  parameter logic [7:0] MASK_DEFAULT = 8'hFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      mask,
  output logic            busy,
  output logic [3:0]      aborts,
  edp_diag_snap_if.master bus
);

  tSnapState   state, stateNxt;
  tDiagSel     idx;
  logic [7:0]  pend, got;
  logic [7:0]  effMask, pendLeft, encIn;
  logic [2:0]  pIdx, gIdx;
  logic        pNone, gNone;
  logic        capt, abort, gotOne;
  logic [35:0] snapBuf [8];

  assign effMask  = (mask == 8'd0) ? MASK_DEFAULT : mask;
  assign pendLeft = pend & ~(8'd1 << idx);
  // IDLE looks at the incoming mask, capture looks past idx
  assign encIn    = (state == IDLE) ? effMask : pendLeft;
  assign gotOne   = (got != 8'd0) &&
                    ((got & (got - 8'd1)) == 8'd0);

  prio_enc8 uPend (.vec(encIn), .idx(pIdx), .none(pNone));
  prio_enc8 uGot  (.vec(got),   .idx(gIdx), .none(gNone));

  // next state and bus/stream strobes
  always_comb begin
    stateNxt      = state;
    capt          = 1'b0;
    abort         = 1'b0;
    bus.ebus_req  = 1'b0;
    bus.diag_read = 1'b0;
    bus.diag_sel  = 3'd0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !pNone) stateNxt = REQ;
      end
      REQ: begin
        bus.ebus_req = 1'b1;
        if (bus.ebus_grant && !bus.ad_to_ebus)
          stateNxt = ISSUE;
      end
      ISSUE, CAPT: begin
        bus.ebus_req  = 1'b1;
        bus.diag_read = 1'b1;
        bus.diag_sel  = idx;
        abort = bus.ad_to_ebus || !bus.ebus_grant;
        if (abort) begin
          stateNxt = REQ;
        end else if (state == ISSUE) begin
          stateNxt = CAPT;
        end else begin
          capt     = 1'b1;
          stateNxt = pNone ? DRAIN : ISSUE;
        end
      end
      DRAIN: begin
        bus.out_valid = !gNone;
        if (gNone || (bus.out_ready && gotOne))
          stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign bus.out_data = bus.out_valid ? snapBuf[gIdx] : 36'd0;
  assign bus.out_sel  = bus.out_valid ? gIdx : 3'd0;
  assign bus.out_par  = bus.out_valid & ~^snapBuf[gIdx];
  assign bus.out_last = bus.out_valid & gotOne;

  // state, pending/captured sets, cursor and abort counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= dsAR;
      pend   <= 8'd0;
      got    <= 8'd0;
      aborts <= 4'd0;
    end else begin
      state <= stateNxt;
      if (state == IDLE && start) begin
        pend <= effMask;
        got  <= 8'd0;
        idx  <= tDiagSel'(pIdx);
      end
      if (capt) begin
        pend     <= pendLeft;
        got[idx] <= 1'b1;
        idx      <= tDiagSel'(pIdx);
      end
      if (abort && aborts != 4'hF)
        aborts <= aborts + 4'd1;
      if (bus.out_valid && bus.out_ready)
        got[gIdx] <= 1'b0;
    end
  end

  // capture buffer, written only on a clean CAPT cycle
  always_ff @(posedge clk) begin
    if (capt) snapBuf[idx] <= bus.ebus_data;
  end

endmodule

// File: tb/tb_edp_diag_snap.sv
// tb_edp_diag_snap: directed bench for the EDP diag snapshot unit.
// EDP model returns 36'o1000000000+sel one cycle after diag_read.
module tb_edp_diag_snap;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  mask = 8'd0;
  logic        busy;
  logic [3:0]  aborts;

  edp_diag_snap_if bus ();

  edp_diag_snap #(.MASK_DEFAULT(8'hFF)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mask   (mask),
    .busy   (busy),
    .aborts (aborts),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail = 0;

  logic [35:0] edpReg;
  always @(posedge clk)
    if (bus.diag_read)
      edpReg <= 36'o1000000000 + {33'd0, bus.diag_sel};
  assign bus.ebus_data = bus.ad_to_ebus ? 36'o777777777777 : edpReg;

  logic prevRG = 1'b0;
  always @(posedge clk) prevRG <= bus.ebus_req && bus.ebus_grant;
  always @(negedge clk) begin
    if (!reset && bus.diag_read) begin
      nChecks++;
      if (!prevRG) begin
        nFail++;
        $display("FAIL diag_read_guard t=%0t diag_read=1 prev req&grant=0 want 1", $time);
      end
    end
  end

  function automatic logic [35:0] expData(input int s);
    return 36'o1000000000 + 36'(s);
  endfunction

  logic [2:0]  wSel  [8];
  logic [35:0] wData [8];
  logic        wLast [8];
  logic        wPar  [8];
  int          nW, firstCyc, endCyc;
  logic        busyAt1;

  task automatic snap(input string tag, input logic [7:0] m,
                      input int holdOff, input int deny,
                      input int abortSel);
    int cyc, stall;
    logic done, aborted, stallPrev, prevRd, lastPrev;
    logic [35:0] pd;
    logic [2:0] ps, prevSel;
    cyc = 0; stall = 0; done = 0; aborted = 0;
    stallPrev = 0; prevRd = 0; prevSel = 0;
    pd = 0; ps = 0; lastPrev = 0;
    nW = 0; firstCyc = -1; endCyc = -1; busyAt1 = 0;
    @(negedge clk);
    bus.out_ready  = (holdOff == 0);
    bus.ebus_grant = (deny == 0);
    start = 1'b1;
    mask  = m;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      mask  = 8'd0;
      bus.ad_to_ebus = 1'b0;
      bus.ebus_grant = (cyc > deny);
      if (cyc == 1) busyAt1 = busy;
      if (cyc <= deny) begin
        nChecks++;
        if (bus.ebus_req !== 1'b1 || bus.diag_read !== 1'b0) begin
          nFail++;
          $display("FAIL %s deny cyc %0d req=%b diag_read=%b want 1/0",
                   tag, cyc, bus.ebus_req, bus.diag_read);
        end
      end
      if (!aborted && abortSel >= 0 && bus.diag_read && prevRd &&
          bus.diag_sel == prevSel && 32'(bus.diag_sel) == abortSel) begin
        bus.ad_to_ebus = 1'b1;
        aborted = 1'b1;
      end
      prevRd  = bus.diag_read;
      prevSel = bus.diag_sel;
      if (bus.out_valid) begin
        if (firstCyc < 0) firstCyc = cyc;
        if (stallPrev) begin
          nChecks++;
          if (bus.out_data !== pd || bus.out_sel !== ps ||
              bus.out_last !== lastPrev) begin
            nFail++;
            $display("FAIL %s stall cyc %0d sel=%0d data=%o want sel=%0d data=%o",
                     tag, cyc, bus.out_sel, bus.out_data, ps, pd);
          end
        end
        bus.out_ready = (stall >= holdOff);
        if (!bus.out_ready) stall++;
        stallPrev = !bus.out_ready;
        pd = bus.out_data;
        ps = bus.out_sel;
        lastPrev = bus.out_last;
        if (bus.out_ready && nW < 8) begin
          wSel[nW]  = bus.out_sel;
          wData[nW] = bus.out_data;
          wLast[nW] = bus.out_last;
          wPar[nW]  = bus.out_par;
          nW++;
        end
      end else begin
        stallPrev = 1'b0;
      end
      if (!busy && nW > 0) begin
        endCyc = cyc;
        done = 1'b1;
      end
    end
    if (!done) begin
      nChecks++;
      nFail++;
      $display("FAIL %s timeout after %0d cycles words=%0d want done", tag, cyc, nW);
    end
    bus.out_ready  = 1'b1;
    bus.ebus_grant = 1'b1;
    bus.ad_to_ebus = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      nChecks++;
      if ({bus.ebus_req, bus.diag_read, bus.diag_sel, bus.out_valid,
           bus.out_data, bus.out_sel, bus.out_par, bus.out_last,
           busy, aborts} !== 52'd0) begin
        nFail++;
        $display("FAIL reset_outputs pass %0d req=%b rd=%b valid=%b busy=%b aborts=%0d want all 0",
                 i, bus.ebus_req, bus.diag_read, bus.out_valid, busy, aborts);
      end
      reset = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_full(input string tag);
    int k;
    snap(tag, 8'h00, 0, 0, -1);
    nChecks += 4;
    if (busyAt1 !== 1'b1) begin
      nFail++;
      $display("FAIL %s busy_cyc1 got %b want 1", tag, busyAt1);
    end
    if (firstCyc != 18) begin
      nFail++;
      $display("FAIL %s first_valid got %0d want 18", tag, firstCyc);
    end
    if (endCyc != 26) begin
      nFail++;
      $display("FAIL %s busy_fall got %0d want 26", tag, endCyc);
    end
    if (nW != 8) begin
      nFail++;
      $display("FAIL %s word_count got %0d want 8", tag, nW);
    end
    k = 0;
    for (int s = 0; s < 8; s++) begin
      nChecks++;
      if (k >= nW || wSel[k] !== 3'(s) || wData[k] !== expData(s) ||
          wLast[k] !== (s == 7) || wPar[k] !== ~^expData(s)) begin
        nFail++;
        $display("FAIL %s word%0d sel=%0d data=%o last=%b want sel=%0d data=%o",
                 tag, k, wSel[k], wData[k], wLast[k], s, expData(s));
      end
      k++;
    end
  endtask

  task automatic test_sparse();
    logic [7:0] m;
    int k;
    m = 8'b1000_0101;
    snap("sparse", m, 0, 0, -1);
    nChecks += 2;
    if (firstCyc != 8) begin
      nFail++;
      $display("FAIL sparse first_valid got %0d want 8", firstCyc);
    end
    if (nW != 3) begin
      nFail++;
      $display("FAIL sparse word_count got %0d want 3", nW);
    end
    k = 0;
    for (int s = 0; s < 8; s++) begin
      if (!m[s]) continue;
      nChecks++;
      if (k >= nW || wSel[k] !== 3'(s) || wData[k] !== expData(s) ||
          wLast[k] !== (s == 7)) begin
        nFail++;
        $display("FAIL sparse word%0d sel=%0d data=%o last=%b want sel=%0d data=%o",
                 k, wSel[k], wData[k], wLast[k], s, expData(s));
      end
      k++;
    end
  endtask

  task automatic test_backpressure();
    snap("backpressure", 8'hFF, 5, 0, -1);
    nChecks += 2;
    if (nW != 8 || endCyc != 31) begin
      nFail++;
      $display("FAIL backpressure count/end got %0d/%0d want 8/31", nW, endCyc);
    end
    if (wSel[0] !== 3'd0 || wData[0] !== expData(0) ||
        wSel[7] !== 3'd7 || wData[7] !== expData(7)) begin
      nFail++;
      $display("FAIL backpressure ends got sel %0d,%0d want 0,7", wSel[0], wSel[7]);
    end
  endtask

  task automatic test_deny_grant();
    snap("deny_grant", 8'hFF, 0, 10, -1);
    nChecks += 2;
    if (firstCyc != 28) begin
      nFail++;
      $display("FAIL deny_grant first_valid got %0d want 28", firstCyc);
    end
    if (nW != 8 || wData[3] !== expData(3)) begin
      nFail++;
      $display("FAIL deny_grant words got %0d data3=%o want 8 %o",
               nW, wData[3], expData(3));
    end
  endtask

  task automatic test_abort();
    nChecks++;
    if (aborts !== 4'd0) begin
      nFail++;
      $display("FAIL abort_pre got %0d want 0", aborts);
    end
    snap("abort", 8'hFF, 0, 0, 3);
    nChecks += 3;
    if (aborts !== 4'd1) begin
      nFail++;
      $display("FAIL abort_count got %0d want 1", aborts);
    end
    if (firstCyc != 21) begin
      nFail++;
      $display("FAIL abort first_valid got %0d want 21", firstCyc);
    end
    if (nW != 8) begin
      nFail++;
      $display("FAIL abort word_count got %0d want 8", nW);
    end
    for (int k = 0; k < 8; k++) begin
      nChecks++;
      if (wSel[k] !== 3'(k) || wData[k] !== expData(k)) begin
        nFail++;
        $display("FAIL abort word%0d sel=%0d data=%o want sel=%0d data=%o",
                 k, wSel[k], wData[k], k, expData(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.ebus_grant = 1'b1;
    bus.out_ready  = 1'b1;
    start = 1'b1;
    mask  = 8'h00;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    nChecks++;
    if (bus.diag_read !== 1'b1 || bus.diag_sel !== 3'd1) begin
      nFail++;
      $display("FAIL reset_mid precond rd=%b sel=%0d want 1/1",
               bus.diag_read, bus.diag_sel);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nChecks++;
    if ({bus.ebus_req, bus.diag_read, bus.diag_sel, bus.out_valid,
         bus.out_data, bus.out_sel, bus.out_par, bus.out_last,
         busy, aborts} !== 52'd0) begin
      nFail++;
      $display("FAIL reset_mid outputs req=%b rd=%b sel=%0d busy=%b aborts=%0d want all 0",
               bus.ebus_req, bus.diag_read, bus.diag_sel, busy, aborts);
    end
    test_full("after_reset");
  endtask

  initial begin
    bus.ebus_grant = 1'b1;
    bus.ad_to_ebus = 1'b0;
    bus.out_ready  = 1'b1;
    test_reset();
    test_full("full");
    test_sparse();
    test_backpressure();
    test_deny_grant();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/edp_diag_snap.md
# edp_diag_snap

Diagnostic snapshot sequencer, downstream of the EBOX data path's EBUS read port. On a front-end request it steps the EDP diagnostic read mux (DIAG function 12x, sub-select 0–7: AR, BR, MQ, FM, BRX, ARX, ADX, AD). It captures each 36-bit word from EBUS into an 8-entry buffer, then streams the words to the front-end over a valid/ready channel. It owns EBUS only while granted and never overlaps an EDP AD-to-EBUS transfer.

## Interface
Parameters:
- `MASK_DEFAULT`, 8'hFF: reset value of the capture mask. Bit i set means sub-select i is captured (bit 0 = AR … bit 7 = AD).

Ports:
- `clk`  in  1  EBOX clock, same edge the EDP registers its EBUS output on.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a snapshot. Ignored unless `busy`=0.
- `mask`  in  8  capture mask, sampled on `start`. If 0 at `start`, `MASK_DEFAULT` is used instead.
- `ebus_req`  out  1  request for EBUS ownership.
- `ebus_grant`  in  1  EBUS arbiter grant.
- `ad_to_ebus`  in  1  OR of CTL.AD_TO_EBUS_L and CTL.AD_TO_EBUS_R; EDP is forcing AD onto the bus.
- `diag_read`  out  1  drives CTL.DIAG_READ_FUNC_12x.
- `diag_sel`  out  3  drives DIAG_FUNC[4:6].
- `ebus_data`  in  36  EBUS data, bit 0 MSB.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  front-end accepts.
- `out_data`  out  36  captured word.
- `out_sel`  out  3  sub-select the word came from.
- `out_par`  out  1  odd parity of `out_data` (XNOR-reduce).
- `out_last`  out  1  final word of this snapshot.
- `busy`  out  1  sequencer not IDLE.
- `aborts`  out  4  count of captures restarted because of `ad_to_ebus`; saturates at 15.

## Operation
- State machine: IDLE, REQ, ISSUE, CAPT, DRAIN.
- IDLE, on `start`: latch the effective mask into `pend` and `got`←0. If `pend`=0, stay IDLE. Otherwise set `idx` to the lowest set bit of `pend` and go to REQ.
- REQ: assert `ebus_req`. When `ebus_grant` and not `ad_to_ebus`, go to ISSUE.
- ISSUE: assert `diag_read`, `diag_sel`=`idx`, and `ebus_req`. The EDP registers the selected source this cycle. Go to CAPT.
- CAPT: hold `diag_read`, `diag_sel`, and `ebus_req`. At the end of the cycle, write `ebus_data` into `buf[idx]`, set `got[idx]`, and clear `pend[idx]`.
  - If `pend` still has bits set, set `idx` to the next lowest set bit and go to ISSUE, keeping the grant.
  - Otherwise drop `ebus_req` and go to DRAIN.
- Abort rule: in ISSUE or CAPT, if `ad_to_ebus`=1 or `ebus_grant`=0, no write happens and `pend` is unchanged. `aborts` increments (saturating) and the state returns to REQ with the same `idx`.
- DRAIN: present `buf[idx]` for the lowest set bit of `got`.
  - `out_last`=1 when exactly one bit of `got` remains.
  - On `out_valid && out_ready`, clear that bit. If `got` becomes 0, go to IDLE.
- `out_data`, `out_sel`, `out_par`, and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
- `start` in any state other than IDLE is ignored. There is no cancel input.
- Reset from any state: go to IDLE. All outputs go to 0 (`ebus_req`, `diag_read`, `diag_sel`, `out_*`, `busy`, `aborts`). `pend` and `got` clear. Buffer contents are don't-care.

## Timing
- `busy` rises the cycle after `start`.
- With grant held, no aborts, and N mask bits set: REQ takes 1 cycle, then 2 cycles per word. The first `out_valid` comes 2N+2 cycles after the `start` cycle.
- Full mask: `out_valid` at cycle 18. With `out_ready` held at 1, the last word transfers at cycle 25 and `busy` falls at cycle 26.
- Stream throughput: one word per cycle.
- `diag_read` is never asserted unless `ebus_req` and `ebus_grant` were both high in the previous cycle.

## Structure
- Shared package `ebox_pkg` holds:
  - enum `tDiagSel` {dsAR, dsBR, dsMQ, dsFM, dsBRX, dsARX, dsADX, dsAD}, values 0–7;
  - enum `tSnapState`;
  - constant `DIAG_FUNC_12X`.
- One sub-module: `prio_enc8`, an 8-bit lowest-set-bit encoder returning a 3-bit index and a `none` flag. It is used for both `pend` and `got`.
- The buffer is an 8×36 register array; no RAM macro.

## Test plan
- Full snapshot: mask=0 (selects default FF), grant tied high, EBUS model returns 36'o1000000000+sel.
  - Eight words arrive in order sel 0–7 with matching data.
  - `out_last` is set only on sel 7.
  - First `out_valid` at cycle 18.
- Sparse mask 8'b1000_0101: words arrive for sel 0, 2, 7 only, with `out_last` on sel 7. The capture phase is 6 cycles.
- Pulse `ad_to_ebus` during CAPT of sel 3:
  - `aborts`=1;
  - sel 3 is re-captured after the grant;
  - the final data are correct, with no duplicate or missing word.
- Backpressure: hold `out_ready`=0 for 5 cycles in DRAIN. `out_data`/`out_sel` stay stable, and no word is lost when `out_ready` rises.
- Deny grant for 10 cycles: `ebus_req` stays 1, `diag_read` stays 0, and capture proceeds after the grant.
- Assert `reset` mid-CAPT: the next cycle all outputs are 0 and state is IDLE. A new `start` then completes a full snapshot normally.
